cpu5_immenc: RTL and testbench

//  Immediate encoder: inverse of the immediate decode path. Takes an instruction template and a signed

---
 rtl/cpu5_immenc.sv | 105 ++++++++++
 tb/tb_cpu5_immenc.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cpu5_immenc.sv
// cpu5_immenc: packs a signed immediate into I/S/B instruction fields, flags unrepresentable values
// Ports:
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_ready is registered (low only while the skid holds a word)
//   in_instr, in_immtype   template instruction and immediate format select
//   in_imm                 signed immediate (byte offset for B)
//   out_valid/out_ready    output handshake
//   out_instr, out_err     encoded word and "immediate did not fit / bad format" flag
//   err_clr, err_count     synchronous clear and saturating count of delivered error words
`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif
`ifndef CPU5_BRANCHTYPE_SIZE
`define CPU5_BRANCHTYPE_SIZE 2
`endif
`ifndef CPU5_IMMTYPE_I
`define CPU5_IMMTYPE_I 2'd0
`endif
`ifndef CPU5_IMMTYPE_S
`define CPU5_IMMTYPE_S 2'd1
`endif
`ifndef CPU5_IMMTYPE_B
`define CPU5_IMMTYPE_B 2'd2
`endif

module cpu5_immenc #(
    parameter int XLEN  = `CPU5_XLEN,
    parameter int CNT_W = 8
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [XLEN-1:0]                  in_instr,
    input  logic [`CPU5_BRANCHTYPE_SIZE-1:0] in_immtype,
    input  logic [XLEN-1:0]                  in_imm,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [XLEN-1:0]                  out_instr,
    output logic                             out_err,
    input  logic                             err_clr,
    output logic [CNT_W-1:0]                 err_count
);
    logic            fit12, fit13, enc_err, skid_valid, skid_err, accept, xfer;
    logic [XLEN-1:0] enc_instr, skid_instr;

    // 12-bit signed range for I/S; 13-bit even range for B
    assign fit12 = &in_imm[XLEN-1:11] | ~|in_imm[XLEN-1:11];
    assign fit13 = (&in_imm[XLEN-1:12] | ~|in_imm[XLEN-1:12]) & ~in_imm[0];

    always_comb begin
        enc_instr = in_instr;
        enc_err   = 1'b1;
        if (in_immtype == `CPU5_IMMTYPE_I) begin
            enc_instr[31:20] = in_imm[11:0];
            enc_err          = ~fit12;
        end else if (in_immtype == `CPU5_IMMTYPE_S) begin
            enc_instr[31:25] = in_imm[11:5];
            enc_instr[11:7]  = in_imm[4:0];
            enc_err          = ~fit12;
        end else if (in_immtype == `CPU5_IMMTYPE_B) begin
            enc_instr[31]    = in_imm[12];
            enc_instr[30:25] = in_imm[10:5];
            enc_instr[11:8]  = in_imm[4:1];
            enc_instr[7]     = in_imm[11];
            enc_err          = ~fit13;
        end
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;

    // in_ready is low whenever the skid is full, so a skid refill and a new accept never coincide
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_err   <= 1'b0;
        end else if (xfer | ~out_valid) begin
            out_valid  <= skid_valid | accept;
            skid_valid <= 1'b0;
            if (skid_valid) begin
                out_instr <= skid_instr;
                out_err   <= skid_err;
            end else if (accept) begin
                out_instr <= enc_instr;
                out_err   <= enc_err;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_instr <= enc_instr;
            skid_err   <= enc_err;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_count <= '0;
        else if (err_clr) err_count <= '0;
        else if (xfer & out_err & ~&err_count) err_count <= err_count + 1'b1;
    end
endmodule

// File: tb/tb_cpu5_immenc.sv
// tb_cpu5_immenc: directed checks of encoding, error flags, skid backpressure, counter and reset
module tb_cpu5_immenc;
    localparam logic [1:0] TI = 2'd0, TS = 2'd1, TB = 2'd2, TX = 2'd3;

    logic        clk = 0, resetn = 0, in_valid = 0, out_ready = 0, err_clr = 0;
    logic        in_ready, out_valid, out_err;
    logic [1:0]  in_immtype = TI;
    logic [31:0] in_instr = 0, in_imm = 0, out_instr;
    logic [7:0]  err_count;
    int          total = 0, bad = 0;

    cpu5_immenc dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_immtype(in_immtype), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .err_clr(err_clr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [1:0] t, input logic [31:0] imm);
        in_valid   = 1;
        in_instr   = instr;
        in_immtype = t;
        in_imm     = imm;
    endtask

    task automatic send(input logic [31:0] instr, input logic [1:0] t, input logic [31:0] imm);
        drive(instr, t, imm);
        step();
        in_valid = 0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] instr, input logic err);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_instr"}, out_instr, instr);
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
    endtask

    initial begin
        #2;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_ready", {31'd0, in_ready}, 1);
        chk("rst_instr", out_instr, 0);
        chk("rst_err", {31'd0, out_err}, 0);
        chk("rst_cnt", {24'd0, err_count}, 0);
        resetn = 1;
        out_ready = 1;
        step();
        send(32'h00000093, TI, 32'hFFFFFFFF); expect_word("enc_i", 32'hFFF00093, 0);
        send(32'h0020A023, TS, 32'd8);        expect_word("enc_s", 32'h0020A423, 0);
        send(32'h00000063, TB, 32'hFFFFFFFC); expect_word("enc_b", 32'hFE000EE3, 0);
        send(32'h00000093, TI, 32'd2048);     expect_word("err_i", 32'h80000093, 1);
        send(32'h00000063, TB, 32'd6);        expect_word("b_even", 32'h00000363, 0);
        send(32'h00000063, TB, 32'd5);        expect_word("b_odd", 32'h00000263, 1);
        step();
        chk("drained", {31'd0, out_valid}, 0);
        chk("cnt2", {24'd0, err_count}, 2);
        send(32'h12345678, TX, 32'd0);        expect_word("bad_type", 32'h12345678, 1);
        step();
        chk("cnt3", {24'd0, err_count}, 3);
        err_clr = 1; step(); err_clr = 0;
        chk("clr", {24'd0, err_count}, 0);
        for (int i = 0; i < 3; i++) begin
            drive(32'h00000013, TI, i);
            step();
            expect_word("stream", 32'h00000013 | (i << 20), 0);
            chk("stream_rdy", {31'd0, in_ready}, 1);
        end
        in_valid = 0;
        step();
        chk("stream_end", {31'd0, out_valid}, 0);
        out_ready = 0;
        drive(32'h00000013, TI, 32'd10); step();
        chk("bp_rdy1", {31'd0, in_ready}, 1);
        drive(32'h00000013, TI, 32'd11); step();
        chk("bp_rdy2", {31'd0, in_ready}, 0);
        drive(32'h00000013, TI, 32'd12); step();
        chk("bp_rdy3", {31'd0, in_ready}, 0);
        expect_word("bp_hold", 32'h00A00013, 0);
        out_ready = 1; step();
        expect_word("bp_w1", 32'h00B00013, 0);
        chk("bp_rdy4", {31'd0, in_ready}, 1);
        step(); in_valid = 0;
        expect_word("bp_w2", 32'h00C00013, 0);
        step();
        chk("bp_end", {31'd0, out_valid}, 0);
        drive(32'h0, TX, 32'd0);
        for (int i = 0; i < 300; i++) step();
        in_valid = 0;
        step();
        chk("sat", {24'd0, err_count}, 255);
        send(32'h0, TX, 32'd0);
        err_clr = 1; step(); err_clr = 0;
        chk("clr_wins", {24'd0, err_count}, 0);
        chk("clr_xfer", {31'd0, out_valid}, 0);
        send(32'h0, TX, 32'd0); step();
        chk("cnt_pre_rst", {24'd0, err_count}, 1);
        out_ready = 0;
        drive(32'h00000013, TI, 32'd1); step();
        drive(32'h00000013, TI, 32'd2); step();
        in_valid = 0;
        chk("full_rdy", {31'd0, in_ready}, 0);
        #2 resetn = 0;
        #1;
        chk("mrst_valid", {31'd0, out_valid}, 0);
        chk("mrst_ready", {31'd0, in_ready}, 1);
        chk("mrst_cnt", {24'd0, err_count}, 0);
        resetn = 1;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_stale", {31'd0, out_valid}, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
